// File: rtl/gpr_wb_ctrl.sv
// GPR writeback controller: the ALU owns write port 0, and MUL/LSU share port 1
// through a small FIFO. It also keeps a per-register busy scoreboard for issue interlock.
// Optional macro GPR_WB_RR_EN selects round-robin MUL/LSU arbitration; without it, LSU has fixed priority.
module gpr_wb_ctrl #(
    parameter int AW     = 5,
    parameter int DW     = 32,
    parameter int NREG   = 32,
    parameter int FDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_addr,
    input  logic [DW-1:0]            alu_data,
    input  logic                     mul_valid,
    input  logic [AW-1:0]            mul_addr,
    input  logic [DW-1:0]            mul_data,
    output logic                     mul_ready,
    input  logic                     lsu_valid,
    input  logic [AW-1:0]            lsu_addr,
    input  logic [DW-1:0]            lsu_data,
    output logic                     lsu_ready,
    input  logic                     wb_hold,
    input  logic                     iss_valid,
    input  logic [AW-1:0]            iss_addr,
    output logic                     wr0,
    output logic [AW-1:0]            waddr0,
    output logic [DW-1:0]            wd0,
    output logic                     wr1,
    output logic [AW-1:0]            waddr1,
    output logic [DW-1:0]            wd1,
    output logic [NREG-1:0]          busy,
    output logic [$clog2(FDEPTH):0]  fifo_cnt
);
    localparam int PW = $clog2(FDEPTH);

    logic            wr0_q;
    logic [AW-1:0]   waddr0_q;
    logic [DW-1:0]   wd0_q;

    logic [AW-1:0]   fifo_addr_q [FDEPTH];
    logic [DW-1:0]   fifo_data_q [FDEPTH];
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [PW:0]     cnt_q, cnt_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic            empty, full, collide, pop, push, can_push;
    logic            gnt_lsu, gnt_mul;
    logic [AW-1:0]   head_addr, push_addr;
    logic [DW-1:0]   push_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr0_q    <= 1'b0;
            waddr0_q <= '0;
            wd0_q    <= '0;
        end else begin
            wr0_q    <= alu_valid;
            waddr0_q <= alu_addr;
            wd0_q    <= alu_data;
        end
    end

    assign wr0    = wr0_q;
    assign waddr0 = waddr0_q;
    assign wd0    = wd0_q;

    // The head yields to a same-register ALU write, so the FIFO result lands last.
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == (PW+1)'(FDEPTH));
    assign head_addr = fifo_addr_q[rd_ptr_q];
    assign collide   = wr0_q && (waddr0_q == head_addr);
    assign pop       = !empty && !wb_hold && !collide;

    assign wr1    = pop;
    assign waddr1 = head_addr;
    assign wd1    = fifo_data_q[rd_ptr_q];

`ifdef GPR_WB_RR_EN
    logic prio_lsu_q;

    assign gnt_lsu = lsu_valid && (prio_lsu_q || !mul_valid);
    assign gnt_mul = mul_valid && (!prio_lsu_q || !lsu_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_lsu_q <= 1'b1;
        end else if (lsu_ready) begin
            prio_lsu_q <= 1'b0;
        end else if (mul_ready) begin
            prio_lsu_q <= 1'b1;
        end
    end
`else
    assign gnt_lsu = lsu_valid;
    assign gnt_mul = mul_valid && !lsu_valid;
`endif

    assign can_push  = !full || pop;
    assign lsu_ready = can_push && gnt_lsu;
    assign mul_ready = can_push && gnt_mul;
    assign push      = lsu_ready || mul_ready;
    assign push_addr = lsu_ready ? lsu_addr : mul_addr;
    assign push_data = lsu_ready ? lsu_data : mul_data;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < FDEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push) begin
                fifo_addr_q[wr_ptr_q] <= push_addr;
                fifo_data_q[wr_ptr_q] <= push_data;
                wr_ptr_q              <= wr_ptr_q + PW'(1);
            end
        end
    end

    assign fifo_cnt = cnt_q;

    // A new issue to a register outranks a writeback retiring the previous writer.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
        assign busy_d[gi] = (iss_valid && (iss_addr == AW'(gi))) ||
                            (busy_q[gi] && !(wr0_q && (waddr0_q == AW'(gi)))
                                        && !(pop && (head_addr == AW'(gi))));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Scoreboard bench for gpr_wb_ctrl: stimulus queues the expected port writes and a
// negedge monitor retires them. Directed checks cover ready, busy and occupancy.
module tb_gpr_wb_ctrl;
    localparam int AW     = 5;
    localparam int DW     = 32;
    localparam int NREG   = 32;
    localparam int FDEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic                    alu_valid, mul_valid, lsu_valid, wb_hold, iss_valid;
    logic [AW-1:0]           alu_addr, mul_addr, lsu_addr, iss_addr;
    logic [DW-1:0]           alu_data, mul_data, lsu_data;
    logic                    mul_ready, lsu_ready;
    logic                    wr0, wr1;
    logic [AW-1:0]           waddr0, waddr1;
    logic [DW-1:0]           wd0, wd1;
    logic [NREG-1:0]         busy;
    logic [$clog2(FDEPTH):0] fifo_cnt;

    gpr_wb_ctrl #(.AW(AW), .DW(DW), .NREG(NREG), .FDEPTH(FDEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .mul_valid(mul_valid), .mul_addr(mul_addr), .mul_data(mul_data), .mul_ready(mul_ready),
        .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .wb_hold(wb_hold), .iss_valid(iss_valid), .iss_addr(iss_addr),
        .wr0(wr0), .waddr0(waddr0), .wd0(wd0),
        .wr1(wr1), .waddr1(waddr1), .wd1(wd1),
        .busy(busy), .fifo_cnt(fifo_cnt)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wb_t;

    wb_t exp0_q[$];
    wb_t exp1_q[$];
    wb_t e0, e1;
    int  checks = 0;
    int  passes = 0;
    int  li, mi;
    logic g_lsu;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every port write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr0) begin
                if (exp0_q.size() == 0) begin
                    checks++;
                    $display("FAIL wb0_unexpected: got r%0d=%0h, expected no write", waddr0, wd0);
                end else begin
                    e0 = exp0_q.pop_front();
                    $display("wb0 r%0d=%0h (expect r%0d=%0h)", waddr0, wd0, e0.a, e0.d);
                    chk("wb0_addr", 64'(waddr0), 64'(e0.a));
                    chk("wb0_data", 64'(wd0), 64'(e0.d));
                end
            end
            if (wr1) begin
                if (exp1_q.size() == 0) begin
                    checks++;
                    $display("FAIL wb1_unexpected: got r%0d=%0h, expected no write", waddr1, wd1);
                end else begin
                    e1 = exp1_q.pop_front();
                    $display("wb1 r%0d=%0h (expect r%0d=%0h)", waddr1, wd1, e1.a, e1.d);
                    chk("wb1_addr", 64'(waddr1), 64'(e1.a));
                    chk("wb1_data", 64'(wd1), 64'(e1.d));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish within 100us");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        alu_valid = 1'b0; mul_valid = 1'b0; lsu_valid = 1'b0; wb_hold = 1'b0; iss_valid = 1'b0;
        alu_addr = '0; mul_addr = '0; lsu_addr = '0; iss_addr = '0;
        alu_data = '0; mul_data = '0; lsu_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wr0", 64'(wr0), 64'd0);
        chk("rst_wr1", 64'(wr1), 64'd0);
        chk("rst_waddr0", 64'(waddr0), 64'd0);
        chk("rst_wd0", 64'(wd0), 64'd0);
        chk("rst_waddr1", 64'(waddr1), 64'd0);
        chk("rst_wd1", 64'(wd1), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cnt", 64'(fifo_cnt), 64'd0);

        // ALU port 0, latency 1
        next();
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h1234;
        exp0_q.push_back('{a: 5'd3, d: 32'h1234});
        next();
        alu_valid = 1'b0;
        @(negedge clk); chk("alu_wr0", 64'(wr0), 64'd1);
        next();
        @(negedge clk); chk("alu_wr0_off", 64'(wr0), 64'd0);

        // Scoreboard set by issue, cleared by LSU writeback
        next();
        iss_valid = 1'b1; iss_addr = 5'd7;
        next();
        iss_valid = 1'b0;
        @(negedge clk); chk("busy7_set", 64'(busy[7]), 64'd1);
        next();
        lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'hAA;
        exp1_q.push_back('{a: 5'd7, d: 32'hAA});
        @(negedge clk);
        chk("lsu_rdy", 64'(lsu_ready), 64'd1);
        chk("busy7_hold", 64'(busy[7]), 64'd1);
        next();
        lsu_valid = 1'b0;
        @(negedge clk); chk("wr1_r7", 64'(wr1), 64'd1);
        next();
        @(negedge clk); chk("busy7_clr", 64'(busy[7]), 64'd0);

        // Fill under hold, full back-pressure, then in-order drain
        next();
        wb_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            lsu_valid = 1'b1; lsu_addr = AW'(i); lsu_data = DW'(32'h100 + i);
            exp1_q.push_back('{a: AW'(i), d: DW'(32'h100 + i)});
            @(negedge clk); chk("hold_rdy", 64'(lsu_ready), 64'd1);
            next();
        end
        lsu_addr = 5'd5; lsu_data = 32'h105;
        @(negedge clk);
        chk("hold_cnt", 64'(fifo_cnt), 64'd4);
        chk("full_rdy", 64'(lsu_ready), 64'd0);
        chk("hold_wr1", 64'(wr1), 64'd0);
        next();
        lsu_valid = 1'b0; wb_hold = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk); chk("drain_wr1", 64'(wr1), 64'd1);
            next();
        end
        @(negedge clk);
        chk("drain_done", 64'(wr1), 64'd0);
        chk("drain_cnt", 64'(fifo_cnt), 64'd0);

        // Arbitration with both producers valid; reset first so the LSU is preferred
        next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        li = 0; mi = 0;
        for (int k = 0; k < 4; k++) begin
            lsu_valid = 1'b1; lsu_addr = AW'(20 + li); lsu_data = DW'(32'h300 + li);
            mul_valid = 1'b1; mul_addr = AW'(10 + mi); mul_data = DW'(32'h200 + mi);
`ifdef GPR_WB_RR_EN
            g_lsu = ((k % 2) == 0);
`else
            g_lsu = 1'b1;
`endif
            if (g_lsu) exp1_q.push_back('{a: lsu_addr, d: lsu_data});
            else       exp1_q.push_back('{a: mul_addr, d: mul_data});
            @(negedge clk);
            chk("arb_lsu_rdy", 64'(lsu_ready), 64'(g_lsu));
            chk("arb_mul_rdy", 64'(mul_ready), 64'(!g_lsu));
            if (g_lsu) li++;
            else       mi++;
            next();
        end
        lsu_valid = 1'b0; mul_valid = 1'b0;
        repeat (2) next();
        @(negedge clk); chk("arb_cnt", 64'(fifo_cnt), 64'd0);

        // Same-register collision: ALU writes first, FIFO one cycle later
        next();
        lsu_valid = 1'b1; lsu_addr = 5'd5; lsu_data = 32'h22;
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h11;
        exp0_q.push_back('{a: 5'd5, d: 32'h11});
        exp1_q.push_back('{a: 5'd5, d: 32'h22});
        next();
        lsu_valid = 1'b0; alu_valid = 1'b0;
        @(negedge clk);
        chk("col_wr0", 64'(wr0), 64'd1);
        chk("col_wr1", 64'(wr1), 64'd0);
        next();
        @(negedge clk);
        chk("col_wr1_late", 64'(wr1), 64'd1);
        chk("col_waddr1", 64'(waddr1), 64'd5);

        // Issue and writeback of r9 in the same cycle: set wins
        next();
        lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_data = 32'h99;
        exp1_q.push_back('{a: 5'd9, d: 32'h99});
        next();
        lsu_valid = 1'b0; iss_valid = 1'b1; iss_addr = 5'd9;
        @(negedge clk); chk("sb_wr1", 64'(wr1), 64'd1);
        next();
        iss_valid = 1'b0;
        @(negedge clk); chk("sb_set_wins", 64'(busy[9]), 64'd1);
        next();
        @(negedge clk); chk("sb_stays", 64'(busy[9]), 64'd1);

        // Reset with three entries held in the FIFO discards them
        next();
        wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lsu_valid = 1'b1; lsu_addr = AW'(12 + i); lsu_data = DW'(32'h500 + i);
            next();
        end
        lsu_valid = 1'b0;
        @(negedge clk); chk("rst_pre_cnt", 64'(fifo_cnt), 64'd3);
        next();
        rst = 1'b1; wb_hold = 1'b0;
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_cnt", 64'(fifo_cnt), 64'd0);
        chk("rst_mid_wr1", 64'(wr1), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        next();

        chk("exp0_left", 64'(exp0_q.size()), 64'd0);
        chk("exp1_left", 64'(exp1_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/gpr_wb_ctrl.md
Name: gpr_wb_ctrl

Overview:
- Write side of the two-write-port GPR. Collects results from three producers and drives the GPR write ports wr0/waddr0/wd0 and wr1/waddr1/wd1: ALU (fixed latency, never stalls), MUL and LSU (variable latency, valid/ready).
- Port 0 is dedicated to the ALU. Port 1 is fed by a small writeback FIFO shared by MUL and LSU.
- Keeps a per-register busy scoreboard that issue logic uses for RAW/WAW interlock.

Parameters:
- AW, 5, GPR address width (matches GPR_DEPTH)
- DW, 32, GPR data width (matches GPR_WIDTH)
- NREG, 32, number of GPRs (matches GPR_SIZE)
- FDEPTH, 4, writeback FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- alu_valid  in  1  ALU result valid
- alu_addr  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- mul_valid  in  1  MUL result offered
- mul_addr  in  AW  MUL destination register
- mul_data  in  DW  MUL result
- mul_ready  out  1  MUL result accepted this cycle
- lsu_valid  in  1  LSU result offered
- lsu_addr  in  AW  LSU destination register
- lsu_data  in  DW  LSU result
- lsu_ready  out  1  LSU result accepted this cycle
- wb_hold  in  1  freeze port-1 drain (exception/debug)
- iss_valid  in  1  instruction issued with a GPR destination
- iss_addr  in  AW  issued destination register
- wr0  out  1  GPR write-port-0 enable
- waddr0  out  AW  port-0 address
- wd0  out  DW  port-0 data
- wr1  out  1  GPR write-port-1 enable
- waddr1  out  AW  port-1 address
- wd1  out  DW  port-1 data
- busy  out  NREG  scoreboard; bit i = write to GPR i pending
- fifo_cnt  out  log2(FDEPTH)+1  FIFO occupancy

Behaviour:
- Reset, synchronous on rst=1 at the rising edge:
  - wr0, wr1, waddr0/1, wd0/1 = 0; busy = 0; FIFO empty; fifo_cnt = 0; arbiter pointer selects LSU.
  - mul_ready/lsu_ready may be 1 when rst=0 and FIFO not full.
  - A reset mid-operation discards all FIFO contents and pending port-0 data.
- Port 0:
  - Registered; latency 1. wr0/waddr0/wd0 at cycle N+1 equal alu_valid/alu_addr/alu_data at cycle N.
  - No stall path.
- FIFO push:
  - Combinational ready. At most one push per cycle.
  - If FIFO not full (or full and popping this cycle), exactly one of mul_ready/lsu_ready goes high for the selected valid requester; the other stays low.
  - Transfer occurs when valid && ready. A requester with valid=0 never receives ready.
  - Arbitration when both valid: see Optional Feature.
- FIFO pop:
  - Head drives wr1/waddr1/wd1 directly from storage (registered; no combinational path from producer inputs).
  - wr1 = !empty && !wb_hold && !collide, where collide = wr0 && (waddr0 == head addr).
  - Head pops when wr1=1.
  - On collide the head is held one cycle, so the FIFO result always writes after an ALU result to the same register in the same cycle (FIFO result treated as younger).
  - Push and pop in the same cycle: fifo_cnt unchanged. Pointers wrap modulo FDEPTH.
  - Full: both readies low unless popping this cycle. Empty: wr1 = 0.
- Scoreboard:
  - Set busy[iss_addr] when iss_valid.
  - Clear busy[waddr0] when wr0; clear busy[waddr1] when wr1.
  - Set and clear on the same register in the same cycle: set wins.
  - busy is registered; updates are visible the next cycle.
  - Clearing an already-clear bit is a no-op.

Optional Feature:
- Macro GPR_WB_RR_EN.
- Defined: round-robin arbitration between MUL and LSU. After a grant, the pointer moves to the other requester. With both valid continuously, grants alternate every accepted push.
- Undefined: fixed priority, LSU over MUL. The pointer logic is absent.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Reset then alu_valid=1, alu_addr=3, alu_data=0x1234 at cycle 0 -> wr0=1, waddr0=3, wd0=0x1234 at cycle 1; wr0=0 at cycle 2.
- iss_valid for r7 at cycle 0; LSU pushes r7=0xAA at cycle 2 -> busy[7]=1 from cycle 1; wr1=1, waddr1=7 at cycle 3; busy[7]=0 from cycle 4.
- wb_hold=1; LSU pushes r1..r4 on consecutive cycles -> fifo_cnt reaches 4; lsu_ready=0 with lsu_valid=1 on the 5th push; release hold -> r1..r4 written on wr1 in order on 4 consecutive cycles.
- MUL and LSU both valid for 4 cycles, FIFO draining -> with GPR_WB_RR_EN grants are LSU, MUL, LSU, MUL; without it all 4 grants go to LSU and mul_ready=0 throughout.
- FIFO head r5=0x22 while alu_valid writes r5=0x11 -> cycle k: wr0=1 r5=0x11, wr1=0; cycle k+1: wr1=1 r5=0x22.
- iss_valid r9 in the same cycle as wr1 for r9 -> busy[9] remains 1; rst asserted with FIFO holding 3 entries -> next cycle fifo_cnt=0, wr1=0, busy=0.
